// File: rtl/ultrasonido_pkg.sv
// Shared types and timing defaults for the ultrasonic ranging path.
package ultrasonido_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        REPORT    = 3'd4
    } state_t;

    localparam int unsigned COUNT_W   = 8;
    localparam int unsigned COUNT_MAX = 255;

    localparam int unsigned CLK_HZ             = 50_000_000;
    localparam int unsigned DEF_TRIG_CYCLES    = CLK_HZ / 100_000;          // 10 us
    localparam int unsigned DEF_TICK_CYCLES    = (CLK_HZ / 1_000_000) * 29; // 29 us
    localparam int unsigned DEF_TIMEOUT_CYCLES = (CLK_HZ / 1_000) * 38;     // 38 ms

    // Measurement result: round-trip count plus its status flags.
    typedef struct packed {
        logic [COUNT_W-1:0] count;
        logic               timeout;
        logic               overflow;
    } result_t;

    // Counter width for a cycle limit; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/echo_timer_if.sv
// Request/result signals between the ranging controller and the echo timer.
interface echo_timer_if;
    import ultrasonido_pkg::*;

    logic               start;
    logic               echo;
    logic               trigger;
    logic [COUNT_W-1:0] count;
    logic               calculate;
    logic               busy;
    logic               timeout;
    logic               overflow;

    modport master (
        output start, echo,
        input  trigger, count, calculate, busy, timeout, overflow
    );

    modport slave (
        input  start, echo,
        output trigger, count, calculate, busy, timeout, overflow
    );
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level plus a registered copy
// used to flag rising and falling edges of the synchronised signal.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic fall
);
    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= async_in;
            sync <= meta;
            prev <= sync;
        end
    end

    // Both edges see the same three-flop latency, so pulse widths are preserved.
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;
endmodule

// File: rtl/echo_timer.sv
// Ultrasonic front end: fires the sensor trigger, times the echo pulse in
// one-way centimetre ticks and reports the round-trip count with a strobe.
module echo_timer
    import ultrasonido_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int unsigned TICK_CYCLES    = DEF_TICK_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    echo_timer_if.slave bus
);
    localparam int unsigned TRIG_W = cnt_w(TRIG_CYCLES);
    localparam int unsigned TICK_W = cnt_w(TICK_CYCLES);
    localparam int unsigned TO_W   = cnt_w(TIMEOUT_CYCLES);

    state_t            state;
    state_t            state_n;
    logic [TRIG_W-1:0] trig_cnt;
    logic [TRIG_W-1:0] trig_cnt_n;
    logic [TICK_W-1:0] presc;
    logic [TICK_W-1:0] presc_n;
    logic [TO_W-1:0]   to_cnt;
    logic [TO_W-1:0]   to_cnt_n;
    result_t           acc;
    result_t           acc_n;
    result_t           res;
    result_t           res_n;
    logic              trigger_q;
    logic              trigger_n;
    logic              calc_q;
    logic              calc_n;
    logic              busy_q;
    logic              busy_n;

    logic              echo_rise;
    logic              echo_fall;
    logic              trig_done;
    logic              tick;
    logic              to_done;

    sync_edge u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (bus.echo),
        .rise     (echo_rise),
        .fall     (echo_fall)
    );

    assign trig_done = (trig_cnt == TRIG_W'(TRIG_CYCLES - 1));
    assign tick      = (presc == TICK_W'(TICK_CYCLES - 1));
    assign to_done   = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Counters, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_cnt  <= '0;
            presc     <= '0;
            to_cnt    <= '0;
            acc       <= '0;
            res       <= '0;
            trigger_q <= 1'b0;
            calc_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            trig_cnt  <= trig_cnt_n;
            presc     <= presc_n;
            to_cnt    <= to_cnt_n;
            acc       <= acc_n;
            res       <= res_n;
            trigger_q <= trigger_n;
            calc_q    <= calc_n;
            busy_q    <= busy_n;
        end
    end

    // Next-state and datapath decode.
    always_comb begin
        state_n    = state;
        trig_cnt_n = trig_cnt;
        presc_n    = presc;
        to_cnt_n   = to_cnt;
        acc_n      = acc;
        res_n      = res;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n        = TRIG;
                    trig_cnt_n     = '0;
                    presc_n        = '0;
                    to_cnt_n       = '0;
                    acc_n          = '0;
                    res_n.timeout  = 1'b0;
                    res_n.overflow = 1'b0;
                end
            end

            TRIG: begin
                if (trig_done) begin
                    state_n  = WAIT_RISE;
                    to_cnt_n = '0;
                end else begin
                    trig_cnt_n = trig_cnt + TRIG_W'(1);
                end
            end

            WAIT_RISE: begin
                if (echo_rise) begin
                    state_n  = MEASURE;
                    to_cnt_n = '0;
                    presc_n  = '0;
                end else if (to_done) begin
                    state_n       = REPORT;
                    acc_n.timeout = 1'b1;
                end else begin
                    to_cnt_n = to_cnt + TO_W'(1);
                end
            end

            MEASURE: begin
                // The cycle on which the fall is seen still advances the prescaler.
                if (tick) begin
                    presc_n = '0;
                    if (acc.count == COUNT_W'(COUNT_MAX)) begin
                        acc_n.overflow = 1'b1;
                    end else begin
                        acc_n.count = acc.count + COUNT_W'(1);
                    end
                end else begin
                    presc_n = presc + TICK_W'(1);
                end

                if (echo_fall) begin
                    state_n = REPORT;
                end else if (to_done) begin
                    state_n       = REPORT;
                    acc_n.timeout = 1'b1;
                end else begin
                    to_cnt_n = to_cnt + TO_W'(1);
                end
            end

            REPORT: begin
                state_n = IDLE;
                res_n   = acc;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        trigger_n = (state_n == TRIG);
        busy_n    = (state_n != IDLE);
        calc_n    = (state == REPORT);
    end

    assign bus.trigger   = trigger_q;
    assign bus.calculate = calc_q;
    assign bus.busy      = busy_q;
    assign bus.count     = res.count;
    assign bus.timeout   = res.timeout;
    assign bus.overflow  = res.overflow;
endmodule

// File: tb/tb_echo_timer.sv
// Directed bench for echo_timer: a vector table of echo shapes plus hand
// sequences for reset during a measurement and start-request handling.
module tb_echo_timer;
    import ultrasonido_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_r = 1'b0;
    logic echo_r = 1'b0;
    int   dsel = 0;
    int   cyc = 0;

    int passed = 0;
    int total  = 0;

    echo_timer_if b0 ();
    echo_timer_if b1 ();

    // Main instance and a fast-tick instance that can reach saturation.
    echo_timer #(.TRIG_CYCLES(4), .TICK_CYCLES(3), .TIMEOUT_CYCLES(200)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b0.slave)
    );

    echo_timer #(.TRIG_CYCLES(4), .TICK_CYCLES(1), .TIMEOUT_CYCLES(400)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.slave)
    );

    assign b0.start = start_r && (dsel == 0);
    assign b1.start = start_r && (dsel == 1);
    assign b0.echo  = echo_r;
    assign b1.echo  = echo_r;

    logic       trig_m, calc_m, busy_m, to_m, ov_m;
    logic [7:0] count_m;
    assign trig_m  = (dsel == 1) ? b1.trigger   : b0.trigger;
    assign calc_m  = (dsel == 1) ? b1.calculate : b0.calculate;
    assign busy_m  = (dsel == 1) ? b1.busy      : b0.busy;
    assign to_m    = (dsel == 1) ? b1.timeout   : b0.timeout;
    assign ov_m    = (dsel == 1) ? b1.overflow  : b0.overflow;
    assign count_m = (dsel == 1) ? b1.count     : b0.count;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", passed, total);
        $fatal(1);
    end

    typedef struct {
        int sel;
        int delay;      // cycles after trigger falls; negative = echo already high at start
        int width;      // echo high cycles; 0 = no echo
        int exp_count;
        int exp_to;
        int exp_ov;
    } vec_t;

    localparam int NV = 10;
    vec_t vec [NV];

    int r_trig_len, r_wr_cyc, r_fall_cyc, r_calc_cyc;
    int r_count, r_to, r_ov, r_seen, r_calc_after, r_busy_mid, r_busy_end;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end else begin
            passed++;
        end
    endtask

    // One measurement: start pulse, trigger timing, shaped echo, report capture.
    task automatic run_meas(input int sel, input int delay, input int width);
        int guard;
        dsel = sel;
        @(negedge clk);
        start_r = 1'b1;
        if (delay < 0) echo_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        r_trig_len = 0;
        while (trig_m && r_trig_len < 100) begin
            r_trig_len++;
            @(negedge clk);
        end
        r_wr_cyc   = cyc;
        r_busy_mid = int'(busy_m);
        r_fall_cyc = 0;
        fork
            begin
                if (delay >= 0 && width > 0) begin
                    repeat (delay) @(negedge clk);
                    echo_r = 1'b1;
                end
                repeat (width) @(negedge clk);
                echo_r     = 1'b0;
                r_fall_cyc = cyc;
            end
            begin
                guard = 0;
                while (!calc_m && guard < 3000) begin
                    guard++;
                    @(negedge clk);
                end
                r_seen     = int'(calc_m);
                r_calc_cyc = cyc;
                r_count    = int'(count_m);
                r_to       = int'(to_m);
                r_ov       = int'(ov_m);
                r_busy_end = int'(busy_m);
                @(negedge clk);
                r_calc_after = int'(calc_m);
            end
        join
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_calc(output int seen);
        int guard;
        guard = 0;
        while (!calc_m && guard < 3000) begin
            guard++;
            @(negedge clk);
        end
        seen = int'(calc_m);
    endtask

    initial begin
        int    tl;
        int    seen;
        string tag;

        vec[0] = '{0,  5,   30,  10, 0, 0};
        vec[1] = '{0,  3,    9,   3, 0, 0};
        vec[2] = '{0,  2,    1,   0, 0, 0};
        vec[3] = '{0,  2,    3,   1, 0, 0};
        vec[4] = '{0,  4,   11,   3, 0, 0};
        vec[5] = '{0,  4,   12,   4, 0, 0};
        vec[6] = '{0,  0,    0,   0, 1, 0};
        vec[7] = '{0, -1,  300,   0, 1, 0};
        vec[8] = '{1,  3, 1000, 255, 1, 1};
        vec[9] = '{0,  6,  250,  66, 1, 0};

        // Reset, then idle.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("idle trigger",   int'(b0.trigger),   0);
        check("idle calculate", int'(b0.calculate), 0);
        check("idle busy",      int'(b0.busy),      0);
        check("idle count",     int'(b0.count),     0);
        check("idle timeout",   int'(b0.timeout),   0);
        check("idle overflow",  int'(b0.overflow),  0);
        check("idle sat busy",  int'(b1.busy),      0);

        for (int i = 0; i < NV; i++) begin
            run_meas(vec[i].sel, vec[i].delay, vec[i].width);
            tag = $sformatf("v%0d", i);
            check({tag, " trig_len"},       r_trig_len,   4);
            check({tag, " calc_seen"},      r_seen,       1);
            check({tag, " count"},          r_count,      vec[i].exp_count);
            check({tag, " timeout"},        r_to,         vec[i].exp_to);
            check({tag, " overflow"},       r_ov,         vec[i].exp_ov);
            check({tag, " calc_one_cycle"}, r_calc_after, 0);
            check({tag, " busy_mid"},       r_busy_mid,   1);
            check({tag, " busy_end"},       r_busy_end,   0);
            if (vec[i].exp_to == 0) begin
                check({tag, " fall_to_calc"}, r_calc_cyc - r_fall_cyc, 4);
            end else if (vec[i].sel == 0 && (vec[i].width == 0 || vec[i].delay < 0)) begin
                check({tag, " wait_timeout_lat"}, r_calc_cyc - r_wr_cyc, 201);
            end
        end

        // Reset in the middle of a measurement.
        dsel = 0;
        @(negedge clk);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        repeat (8) @(negedge clk);
        echo_r = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst trigger",   int'(b0.trigger),   0);
        check("rst calculate", int'(b0.calculate), 0);
        check("rst busy",      int'(b0.busy),      0);
        check("rst count",     int'(b0.count),     0);
        check("rst timeout",   int'(b0.timeout),   0);
        check("rst overflow",  int'(b0.overflow),  0);
        echo_r = 1'b0;
        reset  = 1'b0;
        repeat (5) @(negedge clk);
        run_meas(0, 5, 9);
        check("post-rst calc_seen",      r_seen,       1);
        check("post-rst count",          r_count,      3);
        check("post-rst timeout",        r_to,         0);
        check("post-rst calc_one_cycle", r_calc_after, 0);

        // Start pulses during TRIG and MEASURE, then held across REPORT.
        dsel = 0;
        @(negedge clk);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        tl = 0;
        while (trig_m && tl < 100) begin
            tl++;
            start_r = (tl == 2);
            @(negedge clk);
        end
        start_r = 1'b0;
        check("ign trig_len", tl, 4);
        repeat (2) @(negedge clk);
        echo_r = 1'b1;
        repeat (6) @(negedge clk);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        repeat (5) @(negedge clk);
        start_r = 1'b1;
        echo_r  = 1'b0;
        wait_calc(seen);
        check("ign calc_seen", seen,           1);
        check("ign count",     int'(count_m),  4);
        check("ign timeout",   int'(to_m),     0);
        @(negedge clk);
        check("b2b trigger",   int'(trig_m),   1);
        check("b2b calc_low",  int'(calc_m),   0);
        start_r = 1'b0;
        wait_calc(seen);
        check("b2b calc_seen", seen,           1);
        check("b2b count",     int'(count_m),  0);
        check("b2b timeout",   int'(to_m),     1);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/echo_timer.md
# echo_timer

Front end of the ultrasonic ranging path. On a start request it drives the sensor trigger pulse, then measures the width of the returned echo pulse in ticks of one-way sound travel per centimetre. It hands the 8-bit round-trip count to the downstream halving divisor with a one-cycle `calculate` strobe. It also handles timeouts when no echo arrives and saturation when the echo is too long.

## Interface
Parameters:
- `TRIG_CYCLES`, default 500: trigger high time in clk cycles (10 µs at 50 MHz).
- `TICK_CYCLES`, default 1450: clk cycles per count increment (29 µs, 1 cm one-way at 50 MHz).
- `TIMEOUT_CYCLES`, default 1_900_000: limit on both the wait for the echo to rise and the echo high time (38 ms at 50 MHz).

Ports (`clk` and `reset` first):
- `clk`  in  1: system clock.
- `reset`  in  1: reset, synchronous, active-high.
- `start`  in  1: measurement request; sampled only in IDLE.
- `echo`  in  1: asynchronous sensor echo; synchronised internally.
- `trigger`  out  1: sensor trigger pulse.
- `count`  out  8: round-trip distance count; the downstream stage halves it to get cm.
- `calculate`  out  1: one-cycle strobe; `count` is valid on and after this cycle.
- `busy`  out  1: high in every state except IDLE.
- `timeout`  out  1: set at REPORT when the measurement timed out; held until the next start.
- `overflow`  out  1: set at REPORT when the count saturated; held until the next start.

## Operation
- Echo input: passes through a 2-flop synchroniser, then a registered copy is kept for rising and falling edge detection.
- States:
  - IDLE: `start`=1 → TRIG; clear `timeout`, `overflow` and the internal counters.
  - TRIG: `trigger`=1 for exactly `TRIG_CYCLES` cycles → WAIT_RISE.
  - WAIT_RISE: synchronised echo rising edge → MEASURE. If `TIMEOUT_CYCLES` elapse first → REPORT with `timeout`=1 and count=0.
  - MEASURE: the prescaler counts clk cycles; each time it reaches `TICK_CYCLES` it wraps to 0 and the count increments.
    - Echo falling edge → REPORT.
    - `TIMEOUT_CYCLES` elapsed with echo still high → REPORT with `timeout`=1; the count keeps its current value.
  - REPORT: `count` register updated, `calculate`=1 for one cycle → IDLE.
- Count saturates at 255. Further ticks are ignored and `overflow` is set; it never wraps.
- Partial tick at the falling edge is truncated (floor).
- `count` output register changes only on entry to REPORT and holds its value until the next REPORT.
- `start` held high: a new measurement starts on the cycle after REPORT. The caller is responsible for the sensor's 60 ms re-arm gap.
- `start` outside IDLE: ignored.
- Echo already high on entry to WAIT_RISE: no rising edge is seen, so the measurement times out.
- Reset at any state: next edge → IDLE; `trigger`, `calculate`, `busy`, `timeout`, `overflow`, `count`, all counters and synchroniser flops = 0.

## Timing
- `start` high at edge N → `trigger` high from edge N+1 through N+`TRIG_CYCLES`; WAIT_RISE entered at edge N+`TRIG_CYCLES`+1.
- Echo path latency is 3 cycles, equal on the rising and falling edges, so the measured width equals the true pin width to within ±1 cycle.
- Echo falls → `calculate` high 4 cycles later, from the same edge as the new `count`.
- Timeout: the counter restarts on entry to WAIT_RISE and again on entry to MEASURE. REPORT is entered on the cycle the counter reaches `TIMEOUT_CYCLES`−1.
- `calculate` is never asserted two cycles in a row.
- Reset values of all outputs: 0.

## Structure
- Shared package `ultrasonido_pkg`:
  - state enum (IDLE, TRIG, WAIT_RISE, MEASURE, REPORT);
  - `COUNT_W`=8 and `COUNT_MAX`=255;
  - default timing constants derived from `CLK_HZ`=50_000_000.
- Counter widths: `$clog2` of each parameter.
- One sub-module, `sync_edge`: 2-flop synchroniser plus registered copy, with `rise`/`fall` outputs. The rest is a single FSM with a prescaler, a timeout counter and the count register.

## Test plan
Bench parameters: `TRIG_CYCLES`=4, `TICK_CYCLES`=3, `TIMEOUT_CYCLES`=200.
- Reset, then idle 10 cycles → all outputs 0, `busy`=0.
- Pulse `start`; echo high 30 cycles starting 5 cycles after `trigger` falls → `trigger` high exactly 4 cycles; `count`=10 (±1 at the boundary); `calculate` one cycle; `timeout`=0; `overflow`=0.
- Echo never rises → `calculate` 201 cycles after WAIT_RISE entry; `count`=0; `timeout`=1.
- Echo high 1000 cycles → `count`=255, `overflow`=1, `timeout`=1, no wrap.
- `reset` asserted mid-MEASURE, then released and a fresh 9-cycle echo applied → outputs 0 after reset, then `count`=3 with a normal `calculate`.
- `start` pulsed during TRIG and MEASURE, and held high across REPORT → mid-run pulses ignored; a back-to-back measurement begins the cycle after `calculate`.
